// File: rtl/decode_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : decode_pkg                                                 |
// | Description : Shared types and constants for the RV32I decode stage:    |
// |               opcode values, immediate-format enum and the decoded      |
// |               payload struct carried through the output/skid registers. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package decode_pkg;

  // RV32I major opcodes (full 7-bit field, low two bits always 2'b11)
  localparam logic [6:0] c_op_load     = 7'b0000011;
  localparam logic [6:0] c_op_misc_mem = 7'b0001111;
  localparam logic [6:0] c_op_op_imm   = 7'b0010011;
  localparam logic [6:0] c_op_auipc    = 7'b0010111;
  localparam logic [6:0] c_op_store    = 7'b0100011;
  localparam logic [6:0] c_op_op       = 7'b0110011;
  localparam logic [6:0] c_op_lui      = 7'b0110111;
  localparam logic [6:0] c_op_branch   = 7'b1100011;
  localparam logic [6:0] c_op_jalr     = 7'b1100111;
  localparam logic [6:0] c_op_jal      = 7'b1101111;
  localparam logic [6:0] c_op_system   = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_U    = 3'd3,
    IMM_J    = 3'd4,
    IMM_NONE = 3'd5
  } imm_type_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        illegal;
  } decoded_t;

endpackage
`default_nettype wire

// File: rtl/rv32_imm_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rv32_imm_gen                                               |
// | Description : Combinational RV32I opcode classifier and immediate       |
// |               generator.                                                |
// | Ports       : instr    in  32  instruction word                          |
// |               imm_type out  3  immediate format of the opcode           |
// |               imm      out 32  sign-extended immediate (0 if none)      |
// |               illegal  out  1  unsupported opcode or low bits != 2'b11  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module rv32_imm_gen
  import decode_pkg::*;
(
  input  logic [31:0] instr,
  output imm_type_e   imm_type,
  output logic [31:0] imm,
  output logic        illegal
);

  always_comb begin
    imm_type = IMM_NONE;
    illegal  = 1'b0;
    unique case (instr[6:0])
      c_op_load, c_op_op_imm, c_op_jalr,
      c_op_misc_mem, c_op_system:  imm_type = IMM_I;
      c_op_store:                  imm_type = IMM_S;
      c_op_branch:                 imm_type = IMM_B;
      c_op_lui, c_op_auipc:        imm_type = IMM_U;
      c_op_jal:                    imm_type = IMM_J;
      c_op_op:                     imm_type = IMM_NONE;
      default:                     illegal  = 1'b1;
    endcase
    // Every listed opcode already ends in 2'b11; kept explicit for clarity.
    if (instr[1:0] != 2'b11) begin
      illegal  = 1'b1;
      imm_type = IMM_NONE;
    end
  end

  always_comb begin
    imm = '0;
    unique case (imm_type)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : decode_stage                                               |
// | Description : Fetch->decode receiver. Decodes RV32I fields/immediates   |
// |               of each accepted beat and holds up to two beats (output   |
// |               register + skid register) so execute back-pressure never  |
// |               drops or duplicates an instruction. Flush kills all.      |
// | Ports       : clk, rst            clock, synchronous active-high reset  |
// |               f_valid/f_ready     fetch handshake                        |
// |               f_pc, f_instr       offered beat                           |
// |               flush               discard held and offered beats       |
// |               d_valid/d_ready     execute handshake                      |
// |               d_pc, d_npc, d_opcode, d_funct3, d_funct7, d_rd, d_rs1,    |
// |               d_rs2, d_imm, d_illegal   registered decode results      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 32  // only 32 is supported
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            f_valid,
  output logic            f_ready,
  input  logic [XLEN-1:0] f_pc,
  input  logic [31:0]     f_instr,
  input  logic            flush,
  output logic            d_valid,
  input  logic            d_ready,
  output logic [XLEN-1:0] d_pc,
  output logic [XLEN-1:0] d_npc,
  output logic [6:0]      d_opcode,
  output logic [2:0]      d_funct3,
  output logic [6:0]      d_funct7,
  output logic [4:0]      d_rd,
  output logic [4:0]      d_rs1,
  output logic [4:0]      d_rs2,
  output logic [XLEN-1:0] d_imm,
  output logic            d_illegal
);

  decoded_t    r_out;
  decoded_t    r_skid;
  logic        r_out_valid;
  logic        r_skid_valid;

  decoded_t    w_payload;
  imm_type_e   w_imm_type;
  logic [31:0] w_imm;
  logic        w_illegal;
  logic        w_accept;
  logic        w_consume;

  rv32_imm_gen u_imm_gen (
    .instr    (f_instr),
    .imm_type (w_imm_type),
    .imm      (w_imm),
    .illegal  (w_illegal)
  );

  always_comb begin
    w_payload         = '0;
    w_payload.pc      = f_pc;
    w_payload.npc     = f_pc + 32'd4;
    w_payload.opcode  = f_instr[6:0];
    w_payload.funct3  = f_instr[14:12];
    w_payload.funct7  = f_instr[31:25];
    // S- and B-type have no destination; bits [11:7] carry immediate bits.
    w_payload.rd      = (w_imm_type == IMM_S || w_imm_type == IMM_B) ? 5'd0 : f_instr[11:7];
    w_payload.rs1     = f_instr[19:15];
    w_payload.rs2     = f_instr[24:20];
    w_payload.imm     = w_imm;
    w_payload.illegal = w_illegal;
  end

  // Skid full is the only stall; a full skid implies the output is held too.
  assign f_ready   = !r_skid_valid && !rst;
  assign w_accept  = f_valid && f_ready && !flush;
  assign w_consume = r_out_valid && d_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out        <= '0;
      r_skid       <= '0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_out_valid || w_consume) begin
      // Output slot frees up: oldest beat (skid first) moves in.
      // A new beat cannot arrive while skid is valid, so no three-way case.
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_out        <= w_payload;
        r_out_valid  <= 1'b1;
      end else begin
        r_out_valid  <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid       <= w_payload;
      r_skid_valid <= 1'b1;
    end
  end

  assign d_valid   = r_out_valid;
  assign d_pc      = r_out.pc;
  assign d_npc     = r_out.npc;
  assign d_opcode  = r_out.opcode;
  assign d_funct3  = r_out.funct3;
  assign d_funct7  = r_out.funct7;
  assign d_rd      = r_out.rd;
  assign d_rs1     = r_out.rs1;
  assign d_rs2     = r_out.rs2;
  assign d_imm     = r_out.imm;
  assign d_illegal = r_out.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_decode_stage                                            |
// | Description : Scoreboard bench for decode_stage. Accepted beats push an |
// |               expected record computed by an arithmetic RV32I model;    |
// |               a negedge monitor compares and pops on consumption.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, f_valid, f_ready, flush, d_valid, d_ready, d_illegal;
  logic [31:0] f_pc, f_instr, d_pc, d_npc, d_imm;
  logic [6:0]  d_opcode, d_funct7;
  logic [2:0]  d_funct3;
  logic [4:0]  d_rd, d_rs1, d_rs2;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        illegal;
  } beat_t;

  beat_t q[$];
  logic  prev_rst = 1'b0;

  wire [128:0] w_act = {d_pc, d_npc, d_opcode, d_funct3, d_funct7,
                        d_rd, d_rs1, d_rs2, d_imm, d_illegal};

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .f_valid   (f_valid),
    .f_ready   (f_ready),
    .f_pc      (f_pc),
    .f_instr   (f_instr),
    .flush     (flush),
    .d_valid   (d_valid),
    .d_ready   (d_ready),
    .d_pc      (d_pc),
    .d_npc     (d_npc),
    .d_opcode  (d_opcode),
    .d_funct3  (d_funct3),
    .d_funct7  (d_funct7),
    .d_rd      (d_rd),
    .d_rs1     (d_rs1),
    .d_rs2     (d_rs2),
    .d_imm     (d_imm),
    .d_illegal (d_illegal)
  );

  // Reference decode: immediates assembled with signed arithmetic on bit
  // weights rather than bit concatenation.
  function automatic beat_t model(input logic [31:0] pc, input logic [31:0] instr);
    beat_t      e;
    int         s;
    int         immv;
    logic [6:0] op;
    bit         legal;
    s  = $signed(instr);
    op = instr[6:0];
    legal = op inside {7'h03, 7'h13, 7'h67, 7'h0F, 7'h73, 7'h23,
                       7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
    case (op)
      7'h03, 7'h13, 7'h67, 7'h0F, 7'h73: immv = s >>> 20;
      7'h23: immv = ((s >>> 25) * 32) + int'((instr >> 7) & 32'd31);
      7'h63: immv = ((s >>> 31) * 4096) + int'(((instr >> 7) & 32'd1) * 2048)
                  + int'(((instr >> 25) & 32'd63) * 32) + int'(((instr >> 8) & 32'd15) * 2);
      7'h37, 7'h17: immv = int'(instr & 32'hFFFF_F000);
      7'h6F: immv = ((s >>> 31) * 1048576) + int'(((instr >> 12) & 32'd255) * 4096)
                  + int'(((instr >> 20) & 32'd1) * 2048) + int'(((instr >> 21) & 32'd1023) * 2);
      default: immv = 0;
    endcase
    e.pc      = pc;
    e.npc     = pc + 32'd4;
    e.opcode  = op;
    e.funct3  = instr[14:12];
    e.funct7  = instr[31:25];
    e.rd      = (op == 7'h23 || op == 7'h63) ? 5'd0 : instr[11:7];
    e.rs1     = instr[19:15];
    e.rs2     = instr[24:20];
    e.imm     = legal ? 32'(immv) : 32'd0;
    e.illegal = !legal;
    return e;
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (prev_rst)
      chk("reset_outputs", {d_valid, w_act}, '0);
    if (rst) begin
      chk("f_ready_in_reset", f_ready, 1'b0);
      q.delete();
    end else begin
      chk("d_valid_occupancy", d_valid, q.size() != 0);
      chk("f_ready_occupancy", f_ready, q.size() < 2);
      if (flush) begin
        q.delete();
      end else begin
        if (d_valid && q.size() != 0) begin
          chk("payload", w_act, q[0]);
          if (d_ready) void'(q.pop_front());
        end
        if (f_valid && f_ready) q.push_back(model(f_pc, f_instr));
      end
    end
    prev_rst = rst;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [11] = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h73, 7'h23,
                              7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 9) != 0) w[6:0] = ops[$urandom_range(0, 10)];
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] stall_pc [3] = '{32'h100, 32'h104, 32'h108};
    logic        acc;
    rst = 1'b1; f_valid = 1'b0; f_pc = '0; f_instr = '0; flush = 1'b0; d_ready = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;

    // ADDI x1, x0, 5
    d_ready = 1'b1; f_valid = 1'b1; f_pc = 32'h0; f_instr = 32'h0050_0093;
    cyc(); f_valid = 1'b0;
    @(negedge clk);
    chk("addi_valid", d_valid, 1'b1);
    chk("addi_rd", d_rd, 5'd1);
    chk("addi_rs1", d_rs1, 5'd0);
    chk("addi_imm", d_imm, 32'h5);
    chk("addi_npc", d_npc, 32'h4);
    chk("addi_illegal", d_illegal, 1'b0);
    cyc();

    // BEQ at the top of the address space: npc wraps
    f_valid = 1'b1; f_pc = 32'hFFFF_FFFC; f_instr = 32'hFE00_0EE3;
    cyc(); f_valid = 1'b0;
    @(negedge clk);
    chk("beq_imm", d_imm, 32'hFFFF_FFFC);
    chk("beq_rd", d_rd, 5'd0);
    chk("beq_npc", d_npc, 32'h0);
    cyc();

    // Stall: A held, B in skid, C held at fetch
    d_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      f_valid = 1'b1; f_pc = stall_pc[i]; f_instr = rand_instr();
      if (i < 2) cyc();
    end
    cyc();
    @(negedge clk);
    chk("stall_f_ready", f_ready, 1'b0);
    chk("stall_hold_pc", d_pc, stall_pc[0]);
    cyc();
    d_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("drain_valid", d_valid, 1'b1);
      chk("drain_pc", d_pc, stall_pc[i]);
      acc = f_valid && f_ready;
      cyc();
      if (acc) f_valid = 1'b0;
    end
    f_valid = 1'b0;

    // Flush with both entries full and D offered
    d_ready = 1'b0;
    f_valid = 1'b1; f_pc = 32'h200; f_instr = rand_instr(); cyc();
    f_pc = 32'h204; f_instr = rand_instr(); cyc();
    f_pc = 32'h300; f_instr = 32'h0000_0013; flush = 1'b1;
    cyc(); flush = 1'b0; f_valid = 1'b0;
    @(negedge clk);
    chk("flush_d_valid", d_valid, 1'b0);
    chk("flush_f_ready", f_ready, 1'b1);
    d_ready = 1'b1;
    repeat (3) cyc();

    // Illegal opcode followed by LUI
    f_valid = 1'b1; f_pc = 32'h400; f_instr = 32'h0000_007F;
    cyc();
    f_pc = 32'h404; f_instr = 32'h1234_50B7;
    @(negedge clk);
    chk("illegal_valid", d_valid, 1'b1);
    chk("illegal_flag", d_illegal, 1'b1);
    chk("illegal_imm", d_imm, 32'h0);
    cyc(); f_valid = 1'b0;
    @(negedge clk);
    chk("lui_imm", d_imm, 32'h1234_5000);
    chk("lui_rd", d_rd, 5'd1);
    chk("lui_illegal", d_illegal, 1'b0);
    cyc();

    // Reset with both entries full
    d_ready = 1'b0;
    f_valid = 1'b1; f_pc = 32'h500; f_instr = rand_instr(); cyc();
    f_pc = 32'h504; f_instr = rand_instr(); cyc();
    f_valid = 1'b0; rst = 1'b1;
    cyc();
    @(negedge clk);
    chk("rst_d_valid", d_valid, 1'b0);
    chk("rst_d_pc", d_pc, 32'h0);
    chk("rst_d_imm", d_imm, 32'h0);
    cyc();
    rst = 1'b0; d_ready = 1'b1;
    f_valid = 1'b1; f_pc = 32'h600; f_instr = 32'h0050_0093;
    cyc(); f_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", d_valid, 1'b1);
    chk("post_rst_pc", d_pc, 32'h600);
    cyc();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      f_valid = ($urandom_range(0, 99) < 70);
      f_pc    = $urandom;
      f_instr = rand_instr();
      d_ready = ($urandom_range(0, 99) < 65);
      flush   = ($urandom_range(0, 99) < 4);
      cyc();
    end
    f_valid = 1'b0; flush = 1'b0; d_ready = 1'b1;
    repeat (5) cyc();
    chk("final_queue_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
